// File: rtl/cva5_fuzz_run_ctrl_if.sv
// Core-side bundle between the fuzz run controller and the CVA5 wrapper:
// stall, cache/BP invalidate handshakes and the exception trace.
interface cva5_fuzz_run_ctrl_if;
  logic        dexie_stall;
  logic        icache_set_invalidate_all;
  logic        bp_set_invalidate_all;
  logic        dcache_set_invalidate_all;
  logic        icache_invalidating_all;
  logic        bp_invalidating_all;
  logic        dcache_invalidating_all;
  logic        fuzztr_exception_valid;
  logic [4:0]  fuzztr_exception_code;
  logic [31:0] fuzztr_exception_tval;
  logic [31:0] fuzztr_exception_pc;

  modport master (
    output dexie_stall,
    output icache_set_invalidate_all,
    output bp_set_invalidate_all,
    output dcache_set_invalidate_all,
    input  icache_invalidating_all,
    input  bp_invalidating_all,
    input  dcache_invalidating_all,
    input  fuzztr_exception_valid,
    input  fuzztr_exception_code,
    input  fuzztr_exception_tval,
    input  fuzztr_exception_pc
  );

  modport slave (
    input  dexie_stall,
    input  icache_set_invalidate_all,
    input  bp_set_invalidate_all,
    input  dcache_set_invalidate_all,
    output icache_invalidating_all,
    output bp_invalidating_all,
    output dcache_invalidating_all,
    output fuzztr_exception_valid,
    output fuzztr_exception_code,
    output fuzztr_exception_tval,
    output fuzztr_exception_pc
  );
endinterface

// File: rtl/cva5_fuzz_run_ctrl.sv
// Sequences one fuzzing run: invalidate caches/BP, release the core, stop on
// exception/abort/timeout, drain, then report status and the captured record.
module cva5_fuzz_run_ctrl #(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CNT_W-1:0]         timeout_cycles,
  cva5_fuzz_run_ctrl_if.master     core,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               status,
  output logic [4:0]               exc_code_q,
  output logic [31:0]              exc_tval_q,
  output logic [31:0]              exc_pc_q,
  output logic [CNT_W-1:0]         run_cycles
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INV_REQ,
    INV_WAIT,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] timeout_q, timeout_n;
  logic [CNT_W-1:0] run_n;
  logic [1:0]       status_n;
  logic [4:0]       code_n;
  logic [31:0]      tval_n, pc_n;
  logic             abort_latch, abort_latch_n;
  logic             wait_done, wait_done_n;
  logic [DW-1:0]    drain_cnt, drain_cnt_n;
  logic             flags_busy;
  logic             stall_n, inv_n, busy_n, done_n;

  assign flags_busy = core.icache_invalidating_all | core.bp_invalidating_all |
                      core.dcache_invalidating_all;

  always_comb begin
    state_n       = state;
    timeout_n     = timeout_q;
    run_n         = run_cycles;
    status_n      = status;
    code_n        = exc_code_q;
    tval_n        = exc_tval_q;
    pc_n          = exc_pc_q;
    abort_latch_n = abort_latch;
    wait_done_n   = wait_done;
    drain_cnt_n   = drain_cnt;

    case (state)
      IDLE: begin
        if (start) begin
          state_n       = INV_REQ;
          status_n      = 2'd0;
          code_n        = '0;
          tval_n        = '0;
          pc_n          = '0;
          run_n         = '0;
          abort_latch_n = 1'b0;
          timeout_n     = timeout_cycles;
        end
      end
      INV_REQ: begin
        state_n     = INV_WAIT;
        wait_done_n = 1'b0;
        if (abort) abort_latch_n = 1'b1;
      end
      INV_WAIT: begin
        if (abort) abort_latch_n = 1'b1;
        // First INV_WAIT cycle is unconditional so late-rising flags are seen.
        wait_done_n = 1'b1;
        if (wait_done && !flags_busy) state_n = RUN;
      end
      RUN: begin
        if (run_cycles != '1) run_n = run_cycles + CNT_W'(1);
        drain_cnt_n = '0;
        if (core.fuzztr_exception_valid) begin
          code_n   = core.fuzztr_exception_code;
          tval_n   = core.fuzztr_exception_tval;
          pc_n     = core.fuzztr_exception_pc;
          status_n = 2'd1;
          state_n  = DRAIN;
        end else if (abort || abort_latch) begin
          status_n = 2'd3;
          state_n  = DRAIN;
        end else if (timeout_q != '0 && (run_cycles + CNT_W'(1)) == timeout_q) begin
          status_n = 2'd2;
          state_n  = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state_n = DONE;
        else drain_cnt_n = drain_cnt + DW'(1);
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Outputs are registered versions of what the next state implies.
    stall_n = (state_n != RUN);
    inv_n   = (state_n == INV_REQ);
    busy_n  = (state_n == INV_REQ) || (state_n == INV_WAIT) ||
              (state_n == RUN) || (state_n == DRAIN);
    done_n  = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                          <= IDLE;
      timeout_q                      <= '0;
      run_cycles                     <= '0;
      status                         <= 2'd0;
      exc_code_q                     <= '0;
      exc_tval_q                     <= '0;
      exc_pc_q                       <= '0;
      abort_latch                    <= 1'b0;
      wait_done                      <= 1'b0;
      drain_cnt                      <= '0;
      core.dexie_stall               <= 1'b1;
      core.icache_set_invalidate_all <= 1'b0;
      core.bp_set_invalidate_all     <= 1'b0;
      core.dcache_set_invalidate_all <= 1'b0;
      busy                           <= 1'b0;
      done                           <= 1'b0;
    end else begin
      state                          <= state_n;
      timeout_q                      <= timeout_n;
      run_cycles                     <= run_n;
      status                         <= status_n;
      exc_code_q                     <= code_n;
      exc_tval_q                     <= tval_n;
      exc_pc_q                       <= pc_n;
      abort_latch                    <= abort_latch_n;
      wait_done                      <= wait_done_n;
      drain_cnt                      <= drain_cnt_n;
      core.dexie_stall               <= stall_n;
      core.icache_set_invalidate_all <= inv_n;
      core.bp_set_invalidate_all     <= inv_n;
      core.dcache_set_invalidate_all <= inv_n;
      busy                           <= busy_n;
      done                           <= done_n;
    end
  end

endmodule

// File: tb/tb_cva5_fuzz_run_ctrl.sv
// Randomized scoreboard bench for cva5_fuzz_run_ctrl: the driver pushes the
// expected run outcome, a negedge monitor pops and compares on every done.
module tb_cva5_fuzz_run_ctrl;

  localparam int CNT_W = 32;
  localparam int DRAIN = 4;

  typedef struct {
    logic [1:0]  status;
    logic [31:0] run;
    logic [4:0]  code;
    logic [31:0] tval;
    logic [31:0] pc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] timeout_cycles;
  logic             busy, done;
  logic [1:0]       status;
  logic [4:0]       exc_code_q;
  logic [31:0]      exc_tval_q, exc_pc_q;
  logic [CNT_W-1:0] run_cycles;

  cva5_fuzz_run_ctrl_if core_if();

  cva5_fuzz_run_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .timeout_cycles (timeout_cycles),
    .core           (core_if),
    .busy           (busy),
    .done           (done),
    .status         (status),
    .exc_code_q     (exc_code_q),
    .exc_tval_q     (exc_tval_q),
    .exc_pc_q       (exc_pc_q),
    .run_cycles     (run_cycles)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passed = 0;
  exp_t exp_q[$];
  int   hold_i = 1, hold_b = 1, hold_d = 1;
  int   rem_i = 0, rem_b = 0, rem_d = 0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic bound_fail(input string name);
    checks++;
    $display("[TB] FAIL %s: wait bound expired, got no event, expected one", name);
  endtask

  // Reference outcome: the run ends at the earliest stop cycle; ties go to
  // exception, then abort, then timeout. Absent events are encoded as 0.
  function automatic exp_t model(input int t, input int e, input int a, input bit early,
                                 input logic [4:0] code, input logic [31:0] tval,
                                 input logic [31:0] pc);
    exp_t r;
    int   stop, a_eff;
    a_eff = early ? 1 : a;
    stop  = 1 << 30;
    if (e > 0 && e < stop) stop = e;
    if (a_eff > 0 && a_eff < stop) stop = a_eff;
    if (t > 0 && t < stop) stop = t;
    r.run  = stop;
    r.code = '0; r.tval = '0; r.pc = '0;
    if (e == stop) begin
      r.status = 2'd1; r.code = code; r.tval = tval; r.pc = pc;
    end else if (a_eff == stop) r.status = 2'd3;
    else r.status = 2'd2;
    return r;
  endfunction

  // Core model: flags rise when the invalidate request is seen and hold for a
  // per-cache number of cycles.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      rem_i = 0; rem_b = 0; rem_d = 0;
    end else begin
      if (core_if.icache_set_invalidate_all) rem_i = hold_i; else if (rem_i > 0) rem_i--;
      if (core_if.bp_set_invalidate_all)     rem_b = hold_b; else if (rem_b > 0) rem_b--;
      if (core_if.dcache_set_invalidate_all) rem_d = hold_d; else if (rem_d > 0) rem_d--;
    end
    core_if.icache_invalidating_all = (rem_i > 0);
    core_if.bp_invalidating_all     = (rem_b > 0);
    core_if.dcache_invalidating_all = (rem_d > 0);
  end

  int   run_obs = 0, since_run = 0, since_inv = 1000, inv_cnt = 0;
  logic prev_stall = 1'b1, prev_flags = 1'b0, prev_done = 1'b0;

  always @(negedge clk) begin
    logic flags_any, inv_any;
    exp_t x;
    flags_any = core_if.icache_invalidating_all | core_if.bp_invalidating_all |
                core_if.dcache_invalidating_all;
    inv_any   = core_if.icache_set_invalidate_all | core_if.bp_set_invalidate_all |
                core_if.dcache_set_invalidate_all;
    if (!rst) begin
      run_obs = 0; since_run = 0; since_inv = 1000; inv_cnt = 0;
      prev_stall = 1'b1; prev_flags = 1'b0; prev_done = 1'b0;
    end else begin
      if (inv_any) begin
        check_output("inv_pulse_3way", {core_if.icache_set_invalidate_all,
                     core_if.bp_set_invalidate_all, core_if.dcache_set_invalidate_all}, 3'b111);
        inv_cnt++;
        since_inv = 0;
      end else since_inv++;
      if (!core_if.dexie_stall) begin
        run_obs++;
        since_run = 0;
        if (prev_stall) begin
          check_output("run_entry_flags_clear", prev_flags, 1'b0);
          check_output("inv_wait_min", since_inv >= 3, 1'b1);
        end
      end else since_run++;
      if (prev_done) check_output("done_one_cycle", done, 1'b0);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_done: got done, expected no run pending");
        end else begin
          x = exp_q.pop_front();
          check_output("status", status, x.status);
          check_output("run_cycles", run_cycles, x.run);
          check_output("exc_code_q", exc_code_q, x.code);
          check_output("exc_tval_q", exc_tval_q, x.tval);
          check_output("exc_pc_q", exc_pc_q, x.pc);
          check_output("run_cycles_observed", run_obs, x.run);
          check_output("drain_latency", since_run, DRAIN + 1);
          check_output("inv_pulse_count", inv_cnt, 1);
          check_output("busy_at_done", busy, 1'b0);
          check_output("stall_at_done", core_if.dexie_stall, 1'b1);
        end
        run_obs = 0; inv_cnt = 0;
      end
      prev_stall = core_if.dexie_stall;
      prev_flags = flags_any;
      prev_done  = done;
    end
  end

  task automatic apply_stimulus(input int t, input int e, input int a, input bit early,
                                input int hi, input int hb, input int hd, input bit drain_exc,
                                input logic [4:0] code, input logic [31:0] tval,
                                input logic [31:0] pc);
    int k, guard;
    bit seen;
    exp_q.push_back(model(t, e, a, early, code, tval, pc));
    hold_i = hi; hold_b = hb; hold_d = hd;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    timeout_cycles = t;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    timeout_cycles = $urandom;
    if (early) begin
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    k = 0; seen = 0; guard = 0;
    while (1) begin
      if (!core_if.dexie_stall) begin
        seen = 1;
        k++;
        core_if.fuzztr_exception_valid = (k == e);
        core_if.fuzztr_exception_code  = (k == e) ? code : 5'($urandom);
        core_if.fuzztr_exception_tval  = (k == e) ? tval : $urandom;
        core_if.fuzztr_exception_pc    = (k == e) ? pc : $urandom;
        abort = (k == a);
        start = (k == 2);
      end else if (seen) break;
      if (guard >= 1000) begin
        bound_fail("run_phase");
        break;
      end
      @(posedge clk); #1;
      guard++;
    end
    core_if.fuzztr_exception_valid = drain_exc;
    core_if.fuzztr_exception_code  = ~code;
    core_if.fuzztr_exception_tval  = ~tval;
    core_if.fuzztr_exception_pc    = ~pc;
    abort = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    core_if.fuzztr_exception_valid = 1'b0;
    guard = 0;
    while (!done && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!done) bound_fail("done_wait");
    else begin
      abort = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      check_output("start_in_done_ignored", busy, 1'b0);
    end
  endtask

  task automatic apply_reset_mid_run();
    int k, guard;
    timeout_cycles = '0;
    hold_i = 2; hold_b = 3; hold_d = 2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; guard = 0;
    while (k < 7 && guard < 200) begin
      if (!core_if.dexie_stall) k++;
      if (k < 7) begin
        @(posedge clk); #1;
        guard++;
      end
    end
    if (k < 7) bound_fail("reset_mid_run_reach");
    rst = 1'b0;
    @(posedge clk); #1;
    check_output("rst_mid_stall", core_if.dexie_stall, 1'b1);
    check_output("rst_mid_busy", busy, 1'b0);
    check_output("rst_mid_run_cycles", run_cycles, 0);
    check_output("rst_mid_status", status, 2'd0);
    check_output("rst_mid_inv", core_if.icache_set_invalidate_all, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t, e, a, n;
    bit early;
    rst = 1'b0; start = 1'b0; abort = 1'b0; timeout_cycles = '0;
    core_if.fuzztr_exception_valid = 1'b0;
    core_if.fuzztr_exception_code  = '0;
    core_if.fuzztr_exception_tval  = '0;
    core_if.fuzztr_exception_pc    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_stall", core_if.dexie_stall, 1'b1);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_done", done, 1'b0);
    check_output("reset_status", status, 2'd0);
    check_output("reset_run_cycles", run_cycles, 0);
    check_output("reset_inv", {core_if.icache_set_invalidate_all,
                 core_if.bp_set_invalidate_all, core_if.dcache_set_invalidate_all}, 3'b000);
    rst = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(0, 10, 0, 0, 5, 5, 5, 0, 5'd2, 32'hDEADBEEF, 32'h80000010);
    apply_stimulus(100, 0, 0, 0, 3, 4, 2, 0, 5'd0, 32'h0, 32'h0);
    apply_stimulus(0, 0, 0, 1, 2, 2, 8, 0, 5'd0, 32'h0, 32'h0);
    apply_stimulus(5, 5, 5, 0, 1, 1, 1, 1, 5'd13, 32'h12345678, 32'h80000400);
    apply_stimulus(0, 1, 0, 1, 1, 2, 3, 1, 5'd7, 32'hCAFEF00D, 32'h80000020);

    for (int i = 0; i < 20; i++) begin
      t = $urandom_range(0, 40);
      e = $urandom_range(0, 40);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
      early = ($urandom_range(0, 5) == 0);
      if (t == 0 && e == 0 && a == 0 && !early) t = 30;
      n = $urandom_range(0, 1);
      apply_stimulus(t, e, a, early, $urandom_range(1, 8), $urandom_range(1, 8),
                     $urandom_range(1, 8), n[0], 5'($urandom), $urandom, $urandom);
    end

    apply_reset_mid_run();
    apply_stimulus(12, 0, 0, 0, 2, 2, 2, 0, 5'd0, 32'h0, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
